menu_level_ctrl: RTL
====================

// Module: menu_level_ctrl
// PURPOSE
//  Level-select menu controller. Turns mouse position/button into hover flags
//  for the menu renderer (mouseInLevel1..3) and a one-cycle level-start pulse
//  for the scene sequencer. Enforces level unlock masking, a post-entry click
//  hold-off, and press-and-release-on-same-button click semantics.
// PARAMETERS
//  BOX_X0   160  left edge of all level buttons (inclusive)
//  BOX_X1   480  right edge (exclusive)
//  BOX_Y1    80  top of level-1 button; BOX_Y2 200, BOX_Y3 320 likewise
//  BOX_H     60  button height; row n spans [BOX_Yn, BOX_Yn+BOX_H)
//  HOLDOFF  16'd50000  clk cycles clicks are ignored after menu entry (>=1)
// PORTS
//  clk            in   1   system clock
//  rst            in   1   synchronous, active-high reset
//  menu_en        in   1   menu scene active (from scene sequencer)
//  mouse_x        in   10  cursor x, pixel coords
//  mouse_y        in   10  cursor y
//  mouse_left     in   1   left button level (1 = held)
//  unlocked       in   3   bit n-1 = level n selectable
//  key_valid      in   1   keypress strobe (used only with MENU_KEY_SELECT_EN)
//  key_level      in   2   1..3 = level digit; 0 ignored
//  mouseInLevel1  out  1   hover on level 1 (likewise 2, 3)
//  mouseInLevel2  out  1
//  mouseInLevel3  out  1
//  start_level    out  1   one-cycle launch pulse
//  level_sel      out  2   launched level 1..3; held until next launch
// BEHAVIOUR
//  - Reset: state OFF, all outputs 0, level_sel=0, holdoff cnt=0, btn_q=0.
//  - All outputs registered. press = mouse_left & ~btn_q; rel = ~mouse_left & btn_q.
//  - hit[n] = x in [BOX_X0,BOX_X1) & y in row n & unlocked[n]; rows disjoint.
//  - FSM:
//    OFF:   menu_en=1 -> HOLD, cnt<=HOLDOFF-1.
//    HOLD:  cnt-- each cycle; at cnt==0: mouse_left ? WAIT_REL : IDLE.
//    IDLE:  press & hit[n] -> ARMED, arm<=n; press & no hit -> WAIT_REL.
//    ARMED: rel & hit[arm] -> LAUNCH; rel & ~hit[arm] -> IDLE;
//           held -> stay (leaving/re-entering box allowed).
//    WAIT_REL: ~mouse_left -> IDLE.
//    LAUNCH: start_level=1, level_sel<=arm for exactly this cycle -> DONE.
//    DONE:  wait; menu_en=0 -> OFF. No further launches.
//  - menu_en=0 in any state -> OFF next cycle; armed click discarded;
//    start_level never asserted from OFF. level_sel retained.
//  - Hover: mouseInLevelN <= hit[N] in HOLD/IDLE/ARMED/WAIT_REL, else 0
//    (1-cycle latency from mouse_x/y). Locked level never shows hover.
//  - unlocked[arm] dropping while ARMED -> IDLE, no launch.
//  - Release and re-press in same cycle impossible (level input); press in
//    LAUNCH/DONE ignored.
// CONFIGURATION
//  MENU_KEY_SELECT_EN defined: in IDLE, key_valid & key_level in 1..3 &
//   unlocked[key_level] -> arm<=key_level, LAUNCH next cycle; key beats a
//   simultaneous mouse press. Ignored in all other states.
//  Undefined: key_valid/key_level unconnected internally; mouse only.
// TESTING
//  1 rst=1 2 cycles -> all outputs 0; menu_en=1, unlocked=3'b111, HOLDOFF=4,
//    cursor (200,100) -> mouseInLevel1=1 one cycle after HOLD entered.
//  2 after holdoff: press at (200,220), release at (300,230) -> start_level=1
//    one cycle, level_sel=2; then DONE, second click ignored.
//  3 press (200,340), drag to (10,10), release -> no pulse, back to IDLE;
//    unlocked=3'b011, cursor (200,340) -> mouseInLevel3=0, click no launch.
//  4 button held through menu entry -> WAIT_REL; release on box 1 -> no
//    launch; clicks during HOLD (cnt>0) -> no launch.
//  5 ARMED on level 1, menu_en=0 -> OFF next cycle, start_level stays 0,
//    hovers 0; re-enable -> HOLD restarts full count.
//  6 (MENU_KEY_SELECT_EN) IDLE, key_valid=1 key_level=3 -> start_level 2
//    cycles later, level_sel=3; key_level=0 or locked -> no pulse.

Source files
------------

// File: rtl/menu_level_ctrl.sv
// menu_level_ctrl: level-select menu turning mouse hover/clicks into hover flags and a launch pulse.
// Optional keyboard digit selection is compiled in when MENU_KEY_SELECT_EN is defined.
module menu_level_ctrl #(
    parameter logic [9:0]  BOX_X0  = 10'd160,
    parameter logic [9:0]  BOX_X1  = 10'd480,
    parameter logic [9:0]  BOX_Y1  = 10'd80,
    parameter logic [9:0]  BOX_Y2  = 10'd200,
    parameter logic [9:0]  BOX_Y3  = 10'd320,
    parameter logic [9:0]  BOX_H   = 10'd60,
    parameter logic [15:0] HOLDOFF = 16'd50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       menu_en,
    input  logic [9:0] mouse_x,
    input  logic [9:0] mouse_y,
    input  logic       mouse_left,
    input  logic [2:0] unlocked,
    input  logic       key_valid,
    input  logic [1:0] key_level,
    output logic       mouseInLevel1,
    output logic       mouseInLevel2,
    output logic       mouseInLevel3,
    output logic       start_level,
    output logic [1:0] level_sel
);

    typedef enum logic [2:0] {
        OFF, HOLD, IDLE, ARMED, WAIT_REL, LAUNCH, DONE
    } state_t;

    state_t      state, next_state;
    logic [15:0] cnt, next_cnt;
    logic [1:0]  arm, next_arm;
    logic        btn_q;
    logic        press, rel, in_x, hover_active;
    logic [2:0]  hit;
    logic [1:0]  hit_level;
    logic        hit_arm, unl_arm;
    logic        key_ok;
    logic [1:0]  key_arm;

    assign press = mouse_left & ~btn_q;
    assign rel   = ~mouse_left & btn_q;
    assign in_x  = (mouse_x >= BOX_X0) && (mouse_x < BOX_X1);

    // A locked level never counts as hit, so it can neither hover nor arm.
    assign hit[0] = in_x && (mouse_y >= BOX_Y1) && (mouse_y < BOX_Y1 + BOX_H) && unlocked[0];
    assign hit[1] = in_x && (mouse_y >= BOX_Y2) && (mouse_y < BOX_Y2 + BOX_H) && unlocked[1];
    assign hit[2] = in_x && (mouse_y >= BOX_Y3) && (mouse_y < BOX_Y3 + BOX_H) && unlocked[2];

    assign hit_level = hit[0] ? 2'd1 : (hit[1] ? 2'd2 : 2'd3);

    always_comb begin
        hit_arm = 1'b0;
        unl_arm = 1'b0;
        case (arm)
            2'd1: begin hit_arm = hit[0]; unl_arm = unlocked[0]; end
            2'd2: begin hit_arm = hit[1]; unl_arm = unlocked[1]; end
            2'd3: begin hit_arm = hit[2]; unl_arm = unlocked[2]; end
            default: begin hit_arm = 1'b0; unl_arm = 1'b0; end
        endcase
    end

`ifdef MENU_KEY_SELECT_EN
    always_comb begin
        key_ok  = 1'b0;
        key_arm = key_level;
        case (key_level)
            2'd1:    key_ok = key_valid & unlocked[0];
            2'd2:    key_ok = key_valid & unlocked[1];
            2'd3:    key_ok = key_valid & unlocked[2];
            default: key_ok = 1'b0;
        endcase
    end
`else
    logic unused_key;
    assign unused_key = &{1'b0, key_valid, key_level};
    assign key_ok     = 1'b0;
    assign key_arm    = 2'd0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= OFF;
            cnt   <= 16'd0;
            arm   <= 2'd0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            arm   <= next_arm;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        next_arm   = arm;
        case (state)
            OFF: begin
                if (menu_en) begin
                    next_state = HOLD;
                    next_cnt   = HOLDOFF - 16'd1;
                end
            end
            HOLD: begin
                if (cnt == 16'd0)
                    next_state = mouse_left ? WAIT_REL : IDLE;
                else
                    next_cnt = cnt - 16'd1;
            end
            IDLE: begin
                if (key_ok) begin
                    next_state = LAUNCH;
                    next_arm   = key_arm;
                end else if (press) begin
                    if (|hit) begin
                        next_state = ARMED;
                        next_arm   = hit_level;
                    end else begin
                        next_state = WAIT_REL;
                    end
                end
            end
            ARMED: begin
                if (!unl_arm)
                    next_state = IDLE;
                else if (rel)
                    next_state = hit_arm ? LAUNCH : IDLE;
            end
            WAIT_REL: begin
                if (!mouse_left)
                    next_state = IDLE;
            end
            LAUNCH:  next_state = DONE;
            DONE:    next_state = DONE;
            default: next_state = OFF;
        endcase
        // Leaving the menu scene overrides everything, discarding any armed click.
        if (!menu_en)
            next_state = OFF;
    end

    assign hover_active = menu_en &&
                          ((state == HOLD) || (state == IDLE) ||
                           (state == ARMED) || (state == WAIT_REL));

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q         <= 1'b0;
            mouseInLevel1 <= 1'b0;
            mouseInLevel2 <= 1'b0;
            mouseInLevel3 <= 1'b0;
            start_level   <= 1'b0;
            level_sel     <= 2'd0;
        end else begin
            btn_q         <= mouse_left;
            mouseInLevel1 <= hover_active & hit[0];
            mouseInLevel2 <= hover_active & hit[1];
            mouseInLevel3 <= hover_active & hit[2];
            start_level   <= menu_en && (state == LAUNCH);
            if (menu_en && (state == LAUNCH))
                level_sel <= arm;
        end
    end

endmodule
